// File: rtl/frame_strobe_gen.sv
// rtl/frame_strobe_gen.sv - word-stream frame assembler driving FrameData and a one-hot FrameStrobe pulse
// Optional feature macro: FRAME_AUTOINC_EN (burst command 0x02 with frame auto-increment)
module frame_strobe_gen #(
  parameter int MaxFramesPerCol = 32,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 16,
  parameter int NumColumns      = 8
) (
  input  logic                                   CLK,
  input  logic                                   resetn,
  input  logic [31:0]                            in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [FrameBitsPerRow*NumRows-1:0]     FrameData,
  output logic [MaxFramesPerCol*NumColumns-1:0]  FrameStrobe,
  output logic                                   busy,
  output logic                                   err,
  output logic [15:0]                            frame_count
);

  localparam int StrobeBits = MaxFramesPerCol * NumColumns;
  localparam int StrobeIdxW = (StrobeBits > 1) ? $clog2(StrobeBits) : 1;
  localparam int RowW       = (NumRows > 1) ? $clog2(NumRows) : 1;

  localparam logic [31:0]     SyncWord  = 32'hFAB0_FAB1;
  localparam logic [7:0]      CmdDesync = 8'h00;
  localparam logic [7:0]      CmdWrite  = 8'h01;
  localparam logic [RowW-1:0] RowLast   = RowW'(NumRows - 1);
`ifdef FRAME_AUTOINC_EN
  localparam logic [7:0]      CmdBurst  = 8'h02;
  localparam logic [7:0]      FrmLast   = 8'(MaxFramesPerCol - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_STROBE
  } state_t;

  state_t          state_q;
  logic [7:0]      col_q;
  logic [7:0]      frm_q;
  logic [RowW-1:0] row_q;
  logic            discard_q;
  logic [31:0]     rows_q [NumRows];
`ifdef FRAME_AUTOINC_EN
  logic            burst_q;
`endif

  logic                  accept;
  logic [7:0]            hdr_cmd;
  logic [7:0]            hdr_col;
  logic [7:0]            hdr_frm;
  logic                  hdr_bad;
  logic [StrobeIdxW-1:0] strobe_idx;
  logic [StrobeBits-1:0] strobe_onehot;

  // The only stall is the single strobe cycle, so the loader sees one bubble per frame.
  assign in_ready = (state_q != S_STROBE);
  assign busy     = (state_q != S_IDLE);
  assign accept   = in_valid && in_ready;

  assign hdr_cmd = in_data[31:24];
  assign hdr_col = in_data[23:16];
  assign hdr_frm = in_data[15:8];
  assign hdr_bad = (32'(hdr_col) >= 32'(NumColumns)) ||
                   (32'(hdr_frm) >= 32'(MaxFramesPerCol));

  // Strobe bit for the latched address; only used when the address was in range.
  assign strobe_idx    = StrobeIdxW'(32'(col_q) * 32'(MaxFramesPerCol) + 32'(frm_q));
  assign strobe_onehot = StrobeBits'(1) << strobe_idx;

  // Flatten the row registers onto the fabric FrameData bus, row k at [k*W +: W].
  for (genvar k = 0; k < NumRows; k++) begin : g_rows
    assign FrameData[k*FrameBitsPerRow +: FrameBitsPerRow] = rows_q[k];
  end

  // Protocol FSM with registered strobe, error, counter and frame row storage.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      frm_q       <= '0;
      row_q       <= '0;
      discard_q   <= 1'b0;
      err         <= 1'b0;
      frame_count <= '0;
      FrameStrobe <= '0;
      for (int k = 0; k < NumRows; k++) rows_q[k] <= '0;
`ifdef FRAME_AUTOINC_EN
      burst_q     <= 1'b0;
`endif
    end else begin
      FrameStrobe <= '0;
      case (state_q)
        S_IDLE: begin
          if (accept && in_data == SyncWord) begin
            state_q <= S_HDR;
            err     <= 1'b0;
          end
        end
        S_HDR: begin
          if (accept) begin
            case (hdr_cmd)
              CmdDesync: state_q <= S_IDLE;
`ifdef FRAME_AUTOINC_EN
              CmdWrite, CmdBurst: begin
`else
              CmdWrite: begin
`endif
                // A bad address still consumes the frame's words so the stream stays aligned.
                col_q     <= hdr_col;
                frm_q     <= hdr_frm;
                row_q     <= '0;
                discard_q <= hdr_bad;
                if (hdr_bad) err <= 1'b1;
`ifdef FRAME_AUTOINC_EN
                burst_q   <= (hdr_cmd == CmdBurst);
`endif
                state_q   <= S_DATA;
              end
              default: begin
                err     <= 1'b1;
                state_q <= S_IDLE;
              end
            endcase
          end
        end
        S_DATA: begin
          if (accept) begin
            rows_q[row_q] <= in_data;
            if (row_q == RowLast) begin
              row_q <= '0;
              if (discard_q) begin
                state_q <= S_HDR;
              end else begin
                state_q     <= S_STROBE;
                FrameStrobe <= strobe_onehot;
                frame_count <= frame_count + 16'd1;
              end
            end else begin
              row_q <= row_q + RowW'(1);
            end
          end
        end
        S_STROBE: begin
          state_q <= S_HDR;
`ifdef FRAME_AUTOINC_EN
          // Bursts roll on to the next frame of the column until its last frame.
          if (burst_q && frm_q != FrmLast) begin
            state_q <= S_DATA;
            frm_q   <= frm_q + 8'd1;
            row_q   <= '0;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_strobe_gen.sv
// tb/tb_frame_strobe_gen.sv - directed self-checking bench for frame_strobe_gen
module tb_frame_strobe_gen;
  localparam int MF = 32;
  localparam int NR = 16;
  localparam int NC = 8;

  logic              CLK = 1'b0;
  logic              resetn;
  logic [31:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic [32*NR-1:0]  FrameData;
  logic [MF*NC-1:0]  FrameStrobe;
  logic              busy;
  logic              err;
  logic [15:0]       frame_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int strobe_cnt = 0;
  int strobe_bad = 0;
  int ready_low = 0;

  logic [MF*NC-1:0] exp_s;
  logic [32*NR-1:0] exp_d;
  int s0;
  int r0;

  always #5 CLK = ~CLK;

  frame_strobe_gen #(
    .MaxFramesPerCol(MF),
    .FrameBitsPerRow(32),
    .NumRows(NR),
    .NumColumns(NC)
  ) dut (
    .CLK(CLK),
    .resetn(resetn),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .busy(busy),
    .err(err),
    .frame_count(frame_count)
  );

  // Observe strobe pulses and stall cycles on the falling edge.
  always @(negedge CLK) begin
    if (resetn === 1'b1 && in_ready !== 1'b1) ready_low++;
    if (FrameStrobe != '0) begin
      strobe_cnt++;
      if ($countones(FrameStrobe) != 1) strobe_bad++;
    end
  end

  // Present a word at a falling edge and return at the falling edge after it is taken.
  task automatic send_word(input logic [31:0] w, input bit gap);
    int n;
    n = 0;
    in_data = w;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 8) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 8) begin
      total_cnt++;
      $display("FAIL send_timeout in_ready=%b want 1", in_ready);
    end
    @(negedge CLK);
    if (gap) begin
      in_valid = 1'b0;
      in_data = 32'hDEAD_BEEF;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(negedge CLK);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass_cnt++;
    total_cnt++; if (frame_count !== 16'd0) $display("FAIL reset_count got %0d want 0", frame_count); else pass_cnt++;
    total_cnt++; if (FrameStrobe !== '0) $display("FAIL reset_strobe got nonzero want 0"); else pass_cnt++;
    total_cnt++; if (FrameData !== '0) $display("FAIL reset_data got nonzero want 0"); else pass_cnt++;
    resetn = 1'b1;
    @(negedge CLK);
    send_word(32'h1234_5678, 0);
    total_cnt++; if (busy !== 1'b0) $display("FAIL junk_word_busy got %b want 0", busy); else pass_cnt++;
    send_word(32'hFAB0_FAB1, 0);
    in_valid = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL sync_busy got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL sync_err got %b want 0", err); else pass_cnt++;
  endtask

  task automatic test_write_frame(input bit throttle, input logic [15:0] exp_count);
    s0 = strobe_cnt;
    r0 = ready_low;
    send_word(32'h0102_0500, throttle);
    for (int k = 0; k < NR; k++) send_word(32'h1000 + 32'(k), (k != NR - 1) ? throttle : 1'b0);
    in_valid = 1'b0;
    exp_s = '0;
    exp_s[2*MF+5] = 1'b1;
    total_cnt++; if (FrameStrobe !== exp_s) $display("FAIL wr%0b_strobe got %h want %h", throttle, FrameStrobe, exp_s); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL wr%0b_stall got %b want 0", throttle, in_ready); else pass_cnt++;
    total_cnt++; if (frame_count !== exp_count) $display("FAIL wr%0b_count got %0d want %0d", throttle, frame_count, exp_count); else pass_cnt++;
    for (int k = 0; k < NR; k++) exp_d[k*32 +: 32] = 32'h1000 + 32'(k);
    total_cnt++; if (FrameData !== exp_d) $display("FAIL wr%0b_data got %h want %h", throttle, FrameData, exp_d); else pass_cnt++;
    @(negedge CLK);
    total_cnt++; if (FrameStrobe !== '0) $display("FAIL wr%0b_strobe_width got %h want 0", throttle, FrameStrobe); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1 || busy !== 1'b1) $display("FAIL wr%0b_after got ready=%b busy=%b want 1 1", throttle, in_ready, busy); else pass_cnt++;
    @(negedge CLK);
    total_cnt++; if (strobe_cnt - s0 !== 1) $display("FAIL wr%0b_strobe_cnt got %0d want 1", throttle, strobe_cnt - s0); else pass_cnt++;
    total_cnt++; if (ready_low - r0 !== 1) $display("FAIL wr%0b_stall_cnt got %0d want 1", throttle, ready_low - r0); else pass_cnt++;
  endtask

  task automatic test_bad_col();
    s0 = strobe_cnt;
    send_word(32'h0109_0000, 0);
    total_cnt++; if (err !== 1'b1) $display("FAIL badcol_err got %b want 1", err); else pass_cnt++;
    for (int k = 0; k < NR; k++) send_word(32'h3000 + 32'(k), 0);
    in_valid = 1'b0;
    @(negedge CLK);
    total_cnt++; if (strobe_cnt !== s0) $display("FAIL badcol_strobes got %0d want %0d", strobe_cnt, s0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL badcol_hdr got busy=%b want 1", busy); else pass_cnt++;
    send_word(32'h00AB_CDEF, 0);
    in_valid = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL desync_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (err !== 1'b1) $display("FAIL desync_err_sticky got %b want 1", err); else pass_cnt++;
  endtask

  task automatic test_bad_cmd();
    send_word(32'hFAB0_FAB1, 0);
    total_cnt++; if (err !== 1'b0) $display("FAIL badcmd_sync_clear got %b want 0", err); else pass_cnt++;
    send_word(32'h7F00_0000, 0);
    in_valid = 1'b0;
    total_cnt++; if (err !== 1'b1 || busy !== 1'b0) $display("FAIL badcmd got err=%b busy=%b want 1 0", err, busy); else pass_cnt++;
    send_word(32'hFAB0_FAB1, 0);
    in_valid = 1'b0;
    total_cnt++; if (err !== 1'b0 || busy !== 1'b1) $display("FAIL badcmd_resync got err=%b busy=%b want 0 1", err, busy); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    send_word(32'h0103_0700, 0);
    for (int k = 0; k < 8; k++) send_word(32'h4000 + 32'(k), 0);
    in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    total_cnt++; if (FrameData !== '0 || FrameStrobe !== '0) $display("FAIL midrst_data got nonzero want 0"); else pass_cnt++;
    total_cnt++; if (err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL midrst_flags got err=%b busy=%b rdy=%b want 0 0 1", err, busy, in_ready); else pass_cnt++;
    total_cnt++; if (frame_count !== 16'd0) $display("FAIL midrst_count got %0d want 0", frame_count); else pass_cnt++;
    @(negedge CLK);
    resetn = 1'b1;
    s0 = strobe_cnt;
    send_word(32'h0103_0700, 0);
    for (int k = 0; k < NR; k++) send_word(32'h5000 + 32'(k), 0);
    in_valid = 1'b0;
    @(negedge CLK);
    total_cnt++; if (strobe_cnt !== s0 || busy !== 1'b0) $display("FAIL midrst_nosync got strobes=%0d busy=%b want %0d 0", strobe_cnt, busy, s0); else pass_cnt++;
    total_cnt++; if (FrameData !== '0) $display("FAIL midrst_nosync_data got nonzero want 0"); else pass_cnt++;
    send_word(32'hFAB0_FAB1, 0);
    send_word(32'h0103_0700, 0);
    for (int k = 0; k < NR; k++) send_word(32'h6000 + 32'(k), 0);
    in_valid = 1'b0;
    exp_s = '0;
    exp_s[3*MF+7] = 1'b1;
    for (int k = 0; k < NR; k++) exp_d[k*32 +: 32] = 32'h6000 + 32'(k);
    total_cnt++; if (FrameStrobe !== exp_s) $display("FAIL midrst_strobe got %h want %h", FrameStrobe, exp_s); else pass_cnt++;
    total_cnt++; if (frame_count !== 16'd1) $display("FAIL midrst_count1 got %0d want 1", frame_count); else pass_cnt++;
    total_cnt++; if (FrameData !== exp_d) $display("FAIL midrst_frame got %h want %h", FrameData, exp_d); else pass_cnt++;
    @(negedge CLK);
  endtask

  task automatic test_burst();
    s0 = strobe_cnt;
`ifdef FRAME_AUTOINC_EN
    send_word(32'h0200_1E00, 0);
    for (int k = 0; k < NR; k++) send_word(32'h7000 + 32'(k), 0);
    exp_s = '0;
    exp_s[30] = 1'b1;
    total_cnt++; if (FrameStrobe !== exp_s) $display("FAIL burst_strobe30 got %h want %h", FrameStrobe, exp_s); else pass_cnt++;
    for (int k = 0; k < NR; k++) send_word(32'h7100 + 32'(k), 0);
    in_valid = 1'b0;
    exp_s = '0;
    exp_s[31] = 1'b1;
    total_cnt++; if (FrameStrobe !== exp_s) $display("FAIL burst_strobe31 got %h want %h", FrameStrobe, exp_s); else pass_cnt++;
    total_cnt++; if (frame_count !== 16'd3) $display("FAIL burst_count got %0d want 3", frame_count); else pass_cnt++;
    @(negedge CLK);
    total_cnt++; if (strobe_cnt - s0 !== 2) $display("FAIL burst_strobe_cnt got %0d want 2", strobe_cnt - s0); else pass_cnt++;
    send_word(32'h0000_0000, 0);
    in_valid = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL burst_end_hdr got busy=%b want 0", busy); else pass_cnt++;
`else
    send_word(32'h0200_1E00, 0);
    in_valid = 1'b0;
    total_cnt++; if (err !== 1'b1 || busy !== 1'b0) $display("FAIL burst_unknown got err=%b busy=%b want 1 0", err, busy); else pass_cnt++;
    @(negedge CLK);
    total_cnt++; if (strobe_cnt !== s0) $display("FAIL burst_unknown_strobes got %0d want %0d", strobe_cnt, s0); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_write_frame(1'b0, 16'd1);
    test_write_frame(1'b1, 16'd2);
    test_bad_col();
    test_bad_cmd();
    test_reset_midframe();
    test_burst();
    total_cnt++; if (strobe_bad !== 0) $display("FAIL strobe_onehot got %0d bad pulses want 0", strobe_bad); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
